simon_button_input: RTL

- Upstream front end for the Simon game FSM.
- Converts four raw, bouncy, asynchronous push-buttons into the `playerNum[1:0]` / `playerPressed` pair the game consumes.
- Synchronises, debounces, validates (exactly one button) and edge-detects presses, so each physical press produces exactly one single-cycle accept pulse.
- Presses made while input is disabled (Simon's turn, game over) are dropped and never replayed.
- Runs on the same 60 Hz game clock.

---
 rtl/simon_button_input_if.sv | 21 ++
 rtl/simon_button_input.sv | 134 +++++++++++++
 2 files changed

// File: rtl/simon_button_input_if.sv
// Button front-end bus: raw buttons and enable in, accepted-press signals out.
// Ports: btn[3:0] raw buttons, enable; playerNum[1:0], playerPressed, held, invalid.
// master = button/game side driving inputs, slave = simon_button_input.
interface simon_button_input_if;
    logic [3:0] btn;
    logic       enable;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic       held;
    logic       invalid;

    modport master (
        output btn, enable,
        input  playerNum, playerPressed, held, invalid
    );

    modport slave (
        input  btn, enable,
        output playerNum, playerPressed, held, invalid
    );
endinterface

// File: rtl/simon_button_input.sv
// Synchronise, debounce, validate and edge-detect four push-buttons into one accept pulse per press.
// Latency: button stable before edge 1 -> playerPressed high after edge DEBOUNCE+3.
// Backpressure: none; presses seen while enable is low are dropped, never queued.
// Ports: clk, reset (sync, active-high), bus (slave modport of simon_button_input_if).
module simon_button_input #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    simon_button_input_if.slave  bus
);
    localparam logic [7:0] DEB_CNT = 8'(DEBOUNCE);

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        ARMED        = 2'd1,
        HELD         = 2'd2
    } state_t;

    logic [3:0] s1_q, s2_q;
    logic [3:0] deb_q;
    logic       deb_vld_q;
    logic [7:0] cnt_q, cnt_d;
    logic       stable, deb_load;

    state_t     state_q, state_d;
    logic [3:0] latch_q, latch_d;
    logic [1:0] num_q, num_d;
    logic       pressed_q, pressed_d;
    logic       invalid_q, invalid_d;
    logic       onehot;

    function automatic logic [1:0] encode(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        case (v)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // s2 is about to change whenever s1 differs from it; that edge restarts the run.
    always_comb begin
        stable   = (s1_q == s2_q);
        cnt_d    = 8'd0;
        if (stable)
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        deb_load = stable && (cnt_d >= DEB_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 4'd0;
            s2_q      <= 4'd0;
            cnt_q     <= 8'd0;
            deb_q     <= 4'd0;
            deb_vld_q <= 1'b0;
        end else begin
            s1_q  <= bus.btn;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            if (deb_load) begin
                deb_q     <= s2_q;
                deb_vld_q <= 1'b1;
            end
        end
    end

    assign onehot = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_RELEASE;
            latch_q   <= 4'd0;
            num_q     <= 2'd0;
            pressed_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            latch_q   <= latch_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            invalid_q <= invalid_d;
        end
    end

    // Next state. deb is zero straight out of reset without having been debounced, so
    // leaving WAIT_RELEASE also needs deb_vld_q; a button held through reset then stays blocked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_RELEASE: if (deb_vld_q && deb_q == 4'd0) state_d = ARMED;
            ARMED: begin
                if (onehot)
                    state_d = bus.enable ? HELD : WAIT_RELEASE;
                else if (deb_q != 4'd0)
                    state_d = WAIT_RELEASE;
            end
            HELD: begin
                if (deb_q == 4'd0)
                    state_d = ARMED;
                else if (deb_q != latch_q)
                    state_d = WAIT_RELEASE;
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    // Outputs. playerNum only moves on the accepting edge so it is stable under the pulse.
    always_comb begin
        pressed_d = 1'b0;
        invalid_d = 1'b0;
        num_d     = num_q;
        latch_d   = latch_q;
        if (state_q == ARMED) begin
            if (onehot && bus.enable) begin
                pressed_d = 1'b1;
                num_d     = encode(deb_q);
                latch_d   = deb_q;
            end else if (!onehot && deb_q != 4'd0) begin
                invalid_d = 1'b1;
            end
        end
    end

    assign bus.playerNum     = num_q;
    assign bus.playerPressed = pressed_q;
    assign bus.invalid       = invalid_q;
    assign bus.held          = (state_q == HELD);
endmodule
